sha1_host: RTL and testbench



---
 rtl/sha1_host.sv | 167 ++++++++++++++++
 tb/tb_sha1_host.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_host.sv
// sha1_host: bus initiator for the memory-mapped SHA-1 core. It streams 16 message
// words per block into the core's block registers, kicks init/next, polls status,
// and after the last block reads the five digest words back as one 160-bit result.
// Optional feature macro: SHA1_HOST_TIMEOUT_EN (bounded status poll + sticky error).
module sha1_host #(
    parameter int NBLK_W         = 8,
    parameter int TIMEOUT_CYCLES = 127
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NBLK_W-1:0] nblocks,
    output logic              busy,
    output logic              done,
`ifdef SHA1_HOST_TIMEOUT_EN
    output logic              error,
`endif
    output logic [159:0]      digest,
    input  logic              msg_valid,
    input  logic [31:0]       msg_data,
    output logic              msg_ready,
    output logic              sha_cs,
    output logic              sha_we,
    output logic [7:0]        sha_address,
    output logic [31:0]       sha_write_data,
    input  logic [31:0]       sha_read_data
);

    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_BLOCK  = 8'h10;
    localparam logic [7:0] ADDR_DIGEST = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_READ,
        S_FIN
    } state_t;

    state_t            state;
    logic [NBLK_W-1:0] remaining;  // blocks not yet kicked
    logic              first;      // next kick is init rather than next
    logic [3:0]        widx;       // block word index while loading
    logic [2:0]        didx;       // digest word index while reading back

`ifdef SHA1_HOST_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WC_W-1:0] wcnt;         // not-ready polls seen in the current WAIT
`endif

    // Bus and handshake outputs are a pure decode of state and counters.
    always_comb begin
        busy           = (state != S_IDLE);
        done           = (state == S_FIN);
        msg_ready      = 1'b0;
        sha_cs         = 1'b0;
        sha_we         = 1'b0;
        sha_address    = 8'h00;
        sha_write_data = 32'h0;
        case (state)
            S_LOAD: begin
                // A stalled stream must not produce a bus write.
                msg_ready      = 1'b1;
                sha_cs         = msg_valid;
                sha_we         = msg_valid;
                sha_address    = ADDR_BLOCK + {4'h0, widx};
                sha_write_data = msg_data;
            end
            S_KICK: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = ADDR_CTRL;
                sha_write_data = first ? 32'h1 : 32'h2;
            end
            S_WAIT: begin
                sha_cs      = 1'b1;
                sha_address = ADDR_STATUS;
            end
            S_READ: begin
                sha_cs      = 1'b1;
                sha_address = ADDR_DIGEST + {5'h0, didx};
            end
            default: ;
        endcase
    end

    // Command sequencer: load -> kick -> poll per block, then digest read-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            first     <= 1'b0;
            widx      <= '0;
            didx      <= '0;
            digest    <= '0;
`ifdef SHA1_HOST_TIMEOUT_EN
            error     <= 1'b0;
            wcnt      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && nblocks != '0) begin
                        remaining <= nblocks;
                        first     <= 1'b1;
                        widx      <= '0;
                        state     <= S_LOAD;
`ifdef SHA1_HOST_TIMEOUT_EN
                        error     <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (msg_valid) begin
                        // widx wraps to 0 after word 15, ready for the next block.
                        widx <= widx + 4'd1;
                        if (widx == 4'd15) state <= S_KICK;
                    end
                end
                S_KICK: begin
                    first     <= 1'b0;
                    remaining <= remaining - NBLK_W'(1);
                    state     <= S_WAIT;
`ifdef SHA1_HOST_TIMEOUT_EN
                    wcnt      <= '0;
`endif
                end
                S_WAIT: begin
                    if (sha_read_data[0]) begin
                        if (remaining != '0) begin
                            state <= S_LOAD;
                        end else begin
                            didx  <= '0;
                            state <= S_READ;
                        end
                    end
`ifdef SHA1_HOST_TIMEOUT_EN
                    // Ready wins over the timeout on the same cycle.
                    else if (wcnt == WC_W'(TIMEOUT_CYCLES)) begin
                        error <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        wcnt <= wcnt + WC_W'(1);
                    end
`endif
                end
                S_READ: begin
                    case (didx)
                        3'd0:    digest[159:128] <= sha_read_data;
                        3'd1:    digest[127:96]  <= sha_read_data;
                        3'd2:    digest[95:64]   <= sha_read_data;
                        3'd3:    digest[63:32]   <= sha_read_data;
                        default: digest[31:0]    <= sha_read_data;
                    endcase
                    if (didx == 3'd4) state <= S_FIN;
                    else              didx  <= didx + 3'd1;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_host.sv
// tb_sha1_host: directed vectors for sha1_host against a behavioural SHA-1 core
// (81 busy cycles after each kick). Expected digests are the published SHA-1 values.
module tb_sha1_host;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [7:0]   nblocks;
    logic         busy, done;
    logic [159:0] digest;
    logic         msg_valid = 1'b0;
    logic [31:0]  msg_data = 32'h0;
    logic         msg_ready, sha_cs, sha_we;
    logic [7:0]   sha_address;
    logic [31:0]  sha_write_data, sha_read_data;
`ifdef SHA1_HOST_TIMEOUT_EN
    logic         error;
`endif

    always #5 clk = ~clk;

    sha1_host dut (
        .clk(clk), .reset(reset), .start(start), .nblocks(nblocks),
        .busy(busy), .done(done),
`ifdef SHA1_HOST_TIMEOUT_EN
        .error(error),
`endif
        .digest(digest), .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
        .sha_cs(sha_cs), .sha_we(sha_we), .sha_address(sha_address),
        .sha_write_data(sha_write_data), .sha_read_data(sha_read_data)
    );

    localparam logic [159:0] IV      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_TWO = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    function automatic logic [159:0] sha1_f(input logic [159:0] h, input logic [511:0] b);
        logic [31:0] w [0:79];
        logic [31:0] a, bb, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        a = h[159:128]; bb = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (bb & c) | (~bb & d);          k = 32'h5a827999; end
            else if (i < 40) begin f = bb ^ c ^ d;                    k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = bb ^ c ^ d;                    k = 32'hca62c1d6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + bb, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    // ---------------- peripheral model ----------------
    logic [511:0] blk;
    logic [159:0] hreg;
    int           ccnt;
    logic         stub_hold = 1'b0;
    logic [31:0]  ctrl_log [$];
    int           stall_wr = 0;

    // Register writes, init/next compression, busy countdown.
    always @(posedge clk) begin
        if (reset) begin
            blk  <= '0;
            hreg <= '0;
            ccnt <= 0;
        end else if (sha_cs && sha_we) begin
            if (msg_ready && !msg_valid) stall_wr <= stall_wr + 1;
            if (sha_address[7:4] == 4'h1) begin
                blk[511-32*int'(sha_address[3:0]) -: 32] <= sha_write_data;
            end else if (sha_address == 8'h08) begin
                ctrl_log.push_back(sha_write_data);
                if (sha_write_data[0])      hreg <= sha1_f(IV, blk);
                else if (sha_write_data[1]) hreg <= sha1_f(hreg, blk);
                ccnt <= 81;
            end
        end else if (ccnt != 0) begin
            ccnt <= ccnt - 1;
        end
    end

    // Combinational read port.
    always_comb begin
        sha_read_data = 32'h0;
        case (sha_address)
            8'h09: sha_read_data = {31'h0, (ccnt == 0) && !stub_hold};
            8'h20: sha_read_data = hreg[159:128];
            8'h21: sha_read_data = hreg[127:96];
            8'h22: sha_read_data = hreg[95:64];
            8'h23: sha_read_data = hreg[63:32];
            8'h24: sha_read_data = hreg[31:0];
            default: ;
        endcase
    end

    // ---------------- stream driver + monitor ----------------
    logic [31:0] mq [$];
    logic        hs_pend = 1'b0;
    logic        stall_en = 1'b0;
    int          st0 = 0, st1 = 0, st2 = 0;
    int          ncnt = 0, t0 = 0, done_cyc = -1, ndone = 0, nhs = 0;

    always @(negedge clk) begin
        int rel;
        ncnt = ncnt + 1;
        if (hs_pend && mq.size() > 0) begin
            void'(mq.pop_front());
            nhs = nhs + 1;
        end
        if (start && !busy && nblocks != 8'd0) t0 = ncnt;
        rel = ncnt - t0;
        if (mq.size() > 0 && !(stall_en && (rel == st0 || rel == st1 || rel == st2))) begin
            msg_valid = 1'b1;
            msg_data  = mq[0];
        end else begin
            msg_valid = 1'b0;
            msg_data  = 32'h0;
        end
        hs_pend = msg_valid && msg_ready;
        if (done) begin
            done_cyc = ncnt - t0;
            ndone    = ndone + 1;
        end
    end

    // ---------------- checking ----------------
    int nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_msg(input int id);
        mq.delete();
        if (id == 0) begin
            mq.push_back(32'h61626380);
            repeat (14) mq.push_back(32'h0);
            mq.push_back(32'h00000018);
        end else begin
            mq = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
            repeat (15) mq.push_back(32'h0);
            mq.push_back(32'h000001c0);
        end
    endtask

    task automatic pulse_start(input logic [7:0] n);
        @(posedge clk); #1;
        start = 1'b1; nblocks = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int nd0, input string tag);
        int k = 0;
        while (ndone == nd0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        if (ndone == nd0) begin
            nvec++; nerr++;
            $display("FAIL %s: no done within 2000 cycles", tag);
        end
        repeat (2) @(posedge clk);
    endtask

    typedef struct {
        int           msg_id;
        logic [7:0]   nblk;
        bit           stall;
        logic [159:0] exp_dig;
        int           exp_done;
        int           exp_nctrl;
        logic [31:0]  exp_last;
    } vec_t;

    vec_t vt [3];

    initial begin
        int nd0, nh0, nc0, sw0;
        logic [159:0] prev;
        vt[0] = '{0, 8'd1, 1'b0, DIG_ABC, 105, 1, 32'h1};
        vt[1] = '{1, 8'd2, 1'b0, DIG_TWO, 204, 2, 32'h2};
        vt[2] = '{0, 8'd1, 1'b1, DIG_ABC, 108, 1, 32'h1};

        reset = 1'b1; start = 1'b0; nblocks = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_ready", msg_ready, 0);
        chk("rst_bus",   {sha_cs, sha_we, sha_address, sha_write_data}, 0);
        chk("rst_digest", digest, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Table-driven commands.
        for (int i = 0; i < 3; i++) begin
            load_msg(vt[i].msg_id);
            stall_en = vt[i].stall;
            st0 = $urandom_range(2, 5);
            st1 = $urandom_range(7, 10);
            st2 = $urandom_range(12, 15);
            nd0 = ndone; nh0 = nhs; nc0 = ctrl_log.size(); sw0 = stall_wr;
            pulse_start(vt[i].nblk);
            wait_done(nd0, $sformatf("v%0d_done", i));
            stall_en = 1'b0;
            chk($sformatf("v%0d_digest", i), digest, vt[i].exp_dig);
            chk($sformatf("v%0d_done_cyc", i), 160'(done_cyc), 160'(vt[i].exp_done));
            chk($sformatf("v%0d_ndone", i), 160'(ndone - nd0), 1);
            chk($sformatf("v%0d_nctrl", i), 160'(ctrl_log.size() - nc0), 160'(vt[i].exp_nctrl));
            chk($sformatf("v%0d_ctrl_first", i), ctrl_log[nc0], 32'h1);
            chk($sformatf("v%0d_ctrl_last", i), ctrl_log[ctrl_log.size()-1], vt[i].exp_last);
            chk($sformatf("v%0d_words", i), 160'(nhs - nh0), 160'(16 * int'(vt[i].nblk)));
            chk($sformatf("v%0d_stall_wr", i), 160'(stall_wr - sw0), 0);
        end

        // start with nblocks=0 ignored; start during WAIT ignored.
        load_msg(0);
        repeat (16) mq.push_back(32'hdeadbeef);
        nd0 = ndone; nh0 = nhs; nc0 = ctrl_log.size();
        pulse_start(8'd0);
        @(negedge clk);
        chk("nblk0_busy", busy, 0);
        pulse_start(8'd1);
        repeat (30) @(posedge clk);
        #1 start = 1'b1; nblocks = 8'd5;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("wait_start_busy", busy, 1);
        wait_done(nd0, "ign_done");
        chk("ign_digest",   digest, DIG_ABC);
        chk("ign_done_cyc", 160'(done_cyc), 105);
        chk("ign_words",    160'(nhs - nh0), 16);
        chk("ign_ndone",    160'(ndone - nd0), 1);
        chk("ign_nctrl",    160'(ctrl_log.size() - nc0), 1);
        mq.delete();
        @(posedge clk);

        // Reset while loading word 7, then a fresh command.
        load_msg(0);
        nh0 = nhs;
        pulse_start(8'd1);
        for (int k = 0; k < 100 && (nhs - nh0) < 7; k++) @(negedge clk);
        chk("rstmid_at_w7", 160'(nhs - nh0), 7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_busy",   busy, 0);
        chk("rstmid_ready",  msg_ready, 0);
        chk("rstmid_bus",    {sha_cs, sha_we, sha_address, sha_write_data}, 0);
        chk("rstmid_digest", digest, 0);
        chk("rstmid_done",   done, 0);
        @(posedge clk); #1;
        load_msg(0);
        nd0 = ndone;
        pulse_start(8'd1);
        wait_done(nd0, "rstmid_redo");
        chk("rstmid_new_digest", digest, DIG_ABC);
        chk("rstmid_new_cyc",    160'(done_cyc), 105);

`ifdef SHA1_HOST_TIMEOUT_EN
        // Status stuck at 0: abort after the poll budget, digest untouched.
        prev = digest;
        stub_hold = 1'b1;
        load_msg(0);
        nd0 = ndone;
        pulse_start(8'd1);
        wait_done(nd0, "to_done");
        chk("to_error",  error, 1);
        chk("to_cyc",    160'(done_cyc), 146);
        chk("to_digest", digest, prev);
        stub_hold = 1'b0;
        load_msg(0);
        nd0 = ndone;
        pulse_start(8'd1);
        chk("to_err_clr", error, 0);
        wait_done(nd0, "to_redo");
        chk("to_redo_digest", digest, DIG_ABC);
        chk("to_redo_err",    error, 0);
`else
        prev = digest;
        chk("final_digest_hold", prev, DIG_ABC);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
